// File: rtl/alu_bist_pkg.sv
// Shared types, constants and the reference ALU function for the ALU self-test sequencer.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } bist_state_t;

  localparam int unsigned NUM_VECTORS = 1024;
  localparam logic [15:0] MISR_POLY   = 16'h1021;
  localparam logic [15:0] MISR_SEED   = 16'hFFFF;

  // Expected {carry,result}; SUB carry is the no-borrow flag (A >= B).
  function automatic logic [4:0] golden(input alu_op_t op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: maps a packed {op,A,B} vector to the expected {carry,result}.
module alu_golden_model
  import alu_bist_pkg::*;
(
  input  logic [9:0] vec,
  output logic [4:0] expected
);

  always_comb begin
    expected = golden(alu_op_t'(vec[9:8]), vec[7:4], vec[3:0]);
  end

endmodule

// File: rtl/alu_bist_sequencer.sv
// Sweeps all 1024 {op,A,B} vectors through the external ALU and checks each response.
// Optional MISR response compaction is enabled by defining ALU_BIST_MISR_EN.
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned FAIL_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [1:0]        alu_op,
  input  logic [3:0]        alu_result,
  input  logic              alu_carry,
  output logic              busy,
  output logic              done,
  output logic [FAIL_W-1:0] fail_count,
  output logic [9:0]        first_fail,
  output logic [15:0]       signature
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [9:0] LAST_IDX    = 10'(NUM_VECTORS - 1);

  bist_state_t       state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [3:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [9:0]        first_q, first_d;
  logic [9:0]        cur_vec, vec_idx, next_idx;
  logic [4:0]        expected;
  logic              launch, mismatch, is_last;

  // A and B count down while op counts up, so inverting A/B yields a plain up-counter index.
  assign cur_vec  = {alu_op_q, alu_a_q, alu_b_q};
  assign vec_idx  = {alu_op_q, ~alu_a_q, ~alu_b_q};
  assign next_idx = vec_idx + 10'd1;
  assign is_last  = (vec_idx == LAST_IDX);
  assign launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = ({alu_carry, alu_result} != expected);

  alu_golden_model u_golden (
    .vec      (cur_vec),
    .expected (expected)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
      ST_APPLY:         if (settle_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE:        state_d = is_last ? ST_DONE : ST_APPLY;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    settle_d = settle_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    fail_d   = fail_q;
    first_d  = first_q;
    busy_d   = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
    done_d   = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          alu_op_d = 2'b00;
          alu_a_d  = '1;
          alu_b_d  = '1;
          settle_d = SETTLE_LOAD;
          fail_d   = '0;
          first_d  = '0;
        end
      end
      ST_APPLY: begin
        if (settle_q != '0) settle_d = settle_q - 4'd1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          if (fail_q == '0) first_d = cur_vec;
        end
        if (!is_last) begin
          alu_op_d = next_idx[9:8];
          alu_a_d  = ~next_idx[7:4];
          alu_b_d  = ~next_idx[3:0];
          settle_d = SETTLE_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= '0;
      first_q  <= '0;
    end else begin
      settle_q <= settle_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;

`ifdef ALU_BIST_MISR_EN
  logic [15:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (launch) begin
      misr_d = MISR_SEED;
    end else if (state_q == ST_SAMPLE) begin
      misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : '0)
             ^ {11'b0, alu_carry, alu_result};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) misr_q <= '0;
    else        misr_q <= misr_d;
  end

  assign signature = misr_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Self-checking bench for alu_bist_sequencer with a fault-injectable ALU model.
// Signature expectations follow ALU_BIST_MISR_EN.
module tb_alu_bist_sequencer;

  localparam int unsigned SETTLE     = 1;
  localparam int unsigned FAIL_W     = 11;
  localparam int unsigned VEC_CYCLES = 1024 * (SETTLE + 1);

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [3:0]        alu_a, alu_b, alu_result;
  logic [1:0]        alu_op;
  logic              alu_carry, busy, done;
  logic [FAIL_W-1:0] fail_count;
  logic [9:0]        first_fail;
  logic [15:0]       signature;

  logic [1:0]        fault_mode;
  int unsigned       errors = 0;
  int unsigned       checks = 0;
  logic [9:0]        exp_q[$];

  typedef struct {
    logic [1:0]        fm;
    int unsigned       restart_at;
    logic [FAIL_W-1:0] exp_fails;
    logic [9:0]        exp_first;
  } vec_rec_t;

  vec_rec_t tbl[5];

  always #5 clk = ~clk;

  alu_bist_sequencer #(.SETTLE(SETTLE), .FAIL_W(FAIL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .done       (done),
    .fail_count (fail_count),
    .first_fail (first_fail),
    .signature  (signature)
  );

  // fm: 0 good, 1 result[0] stuck-at-0, 2 carry stuck-at-0, 3 OR 0|0 returns 1
  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [1:0] fm);
    int unsigned s;
    logic [4:0]  r;
    case (op)
      2'd0:    s = a + b;
      2'd1:    s = a + 16 - b;
      2'd2:    s = a & b;
      default: s = a | b;
    endcase
    r = s[4:0];
    if (fm == 2'd1) r[0] = 1'b0;
    if (fm == 2'd2) r[4] = 1'b0;
    if (fm == 2'd3 && op == 2'd3 && a == 4'd0 && b == 4'd0) r = 5'b00001;
    return r;
  endfunction

  always_comb begin
    {alu_carry, alu_result} = ref_alu(alu_op, alu_a, alu_b, fault_mode);
  end

  function automatic logic [9:0] vec_of(input int unsigned i);
    return {2'(i / 256), 4'(15 - (i / 16) % 16), 4'(15 - i % 16)};
  endfunction

  function automatic logic [15:0] exp_sig(input logic [1:0] fm);
    logic [15:0] m;
    logic [9:0]  v;
    logic        fb;
    m = 16'hFFFF;
    for (int unsigned i = 0; i < 1024; i++) begin
      v  = vec_of(i);
      fb = m[15];
      m  = {m[14:0], 1'b0};
      if (fb) m = m ^ 16'h1021;
      m[4:0] = m[4:0] ^ ref_alu(v[9:8], v[7:4], v[3:0], fm);
    end
`ifdef ALU_BIST_MISR_EN
    return m;
`else
    return (m & 16'h0000);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [1:0] fm, input int unsigned restart_at,
                           output int unsigned cycles);
    logic [9:0]  vec, prev_vec;
    logic        prev_busy;
    int unsigned iter;
    fault_mode = fm;
    exp_q.delete();
    for (int unsigned i = 0; i < 1024; i++) exp_q.push_back(vec_of(i));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cycles    = 0;
    iter      = 0;
    prev_busy = 1'b0;
    prev_vec  = '0;
    while (!done && iter < VEC_CYCLES + 50) begin
      vec = {alu_op, alu_a, alu_b};
      if (busy) begin
        cycles++;
        if (!prev_busy || vec != prev_vec) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_vector: got %0h expected none", vec);
          end else begin
            check("sb_vector", 32'(vec), 32'(exp_q.pop_front()));
          end
        end
      end
      start     = (restart_at != 0 && cycles == restart_at);
      prev_busy = busy;
      prev_vec  = vec;
      iter++;
      @(negedge clk);
    end
    start = 1'b0;
    check("sweep_cycles", cycles, VEC_CYCLES);
    check("sb_leftover", exp_q.size(), 0);
  endtask

  int unsigned cyc;
  logic [15:0] sig_clean;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    fault_mode = 2'd0;
    sig_clean  = '0;
    tbl[0] = '{fm: 2'd0, restart_at: 0,   exp_fails: 11'd0,   exp_first: 10'h000};
    tbl[1] = '{fm: 2'd1, restart_at: 0,   exp_fails: 11'd512, exp_first: 10'h0FE};
    tbl[2] = '{fm: 2'd2, restart_at: 0,   exp_fails: 11'd256, exp_first: 10'h0FF};
    tbl[3] = '{fm: 2'd3, restart_at: 0,   exp_fails: 11'd1,   exp_first: 10'h300};
    tbl[4] = '{fm: 2'd0, restart_at: 700, exp_fails: 11'd0,   exp_first: 10'h000};

    repeat (3) @(negedge clk);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_first_fail", first_fail, 0);
    check("rst_signature", signature, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned k = 0; k < 5; k++) begin
      run_sweep(tbl[k].fm, tbl[k].restart_at, cyc);
      check("done_level", done, 1);
      check("busy_after", busy, 0);
      check("fail_count", fail_count, tbl[k].exp_fails);
      check("first_fail", first_fail, tbl[k].exp_first);
      check("signature", signature, exp_sig(tbl[k].fm));
      check("hold_last_vec", {alu_op, alu_a, alu_b}, 10'h300);
      if (k == 0) sig_clean = signature;
`ifdef ALU_BIST_MISR_EN
      if (k == 3) check("sig_fault_differs", 32'(signature != sig_clean), 1);
`endif
    end

    // Consecutive clean run must reproduce the same signature.
    run_sweep(2'd0, 0, cyc);
    check("rerun_fail_count", fail_count, 0);
    check("rerun_signature", signature, sig_clean);

    // Reset in the middle of a faulty sweep.
    fault_mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_vec", {alu_op, alu_a, alu_b}, 0);
    check("mid_rst_fail_count", fail_count, 0);
    check("mid_rst_first_fail", first_fail, 0);
    check("mid_rst_signature", signature, 0);
    rst_n = 1'b1;
    run_sweep(2'd0, 0, cyc);
    check("post_rst_done", done, 1);
    check("post_rst_fail_count", fail_count, 0);

    // start coincident with reset: reset wins.
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("start_rst_busy", busy, 0);
    check("start_rst_done", done, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("start_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
